// File: rtl/fft_pkg.sv
// Shared definitions for the SDF FFT stage controllers: FSM states, Q-format
// constants and the quarter-wave twiddle magnitude tables.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_BFLY,
    ST_DRAIN
  } state_e;

  localparam int unsigned N_MAX      = 1024;
  localparam int unsigned QUARTER    = N_MAX / 4;
  localparam int unsigned QTAB_LEN   = QUARTER + 1;
  localparam int unsigned QTAB_W     = 16;
  localparam int unsigned Q_INT_BITS = 2;

  // Rotation by 2*pi/N_MAX in Q.30, used to build cos(2*pi*j/N_MAX), j=0..N_MAX/4.
  localparam int unsigned GEN_FRAC = 30;
  localparam longint      COS_STEP = 64'sd1073721611;
  localparam longint      SIN_STEP = 64'sd6588356;

  // +1.0 in Q2.(tw-2); it stays below the signed tw-bit maximum, so entries never clip.
  function automatic longint q_one(input int unsigned tw);
    return longint'(1) <<< (tw - Q_INT_BITS);
  endfunction

  function automatic logic [QTAB_LEN*QTAB_W-1:0] gen_qtab(input longint scale);
    logic [QTAB_LEN*QTAB_W-1:0] t;
    longint c;
    longint s;
    longint c_nxt;
    t = '0;
    c = longint'(1) <<< GEN_FRAC;
    s = 0;
    for (int unsigned j = 0; j < QTAB_LEN; j++) begin
      t[j*QTAB_W +: QTAB_W] = QTAB_W'((c * scale + (longint'(1) <<< (GEN_FRAC - 1))) >>> GEN_FRAC);
      c_nxt = (c * COS_STEP - s * SIN_STEP) >>> GEN_FRAC;
      s     = (s * COS_STEP + c * SIN_STEP) >>> GEN_FRAC;
      c     = c_nxt;
    end
    return t;
  endfunction

  localparam logic [QTAB_LEN*QTAB_W-1:0] QTAB_TW8  = gen_qtab(q_one(8));
  localparam logic [QTAB_LEN*QTAB_W-1:0] QTAB_TW10 = gen_qtab(q_one(10));

endpackage

// File: rtl/sdf_stage_ctrl_if.sv
// Sample-side and butterfly-side signals of one SDF stage controller.
interface sdf_stage_ctrl_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned TW = 8
);
  logic          valid_i;
  logic          sop_i;
  logic [DW-1:0] data_in_r;
  logic [DW-1:0] data_in_i;
  logic          ready_o;
  logic [DW-1:0] data_out_r;
  logic [DW-1:0] data_out_i;
  logic          shift_en;
  logic          sel;
  logic          valid_o;
  logic          sop_o;
  logic [TW-1:0] wn_r;
  logic [TW-1:0] wn_i;
  logic          err_o;

  modport master (
    output valid_i, sop_i, data_in_r, data_in_i,
    input  ready_o, data_out_r, data_out_i, shift_en, sel,
           valid_o, sop_o, wn_r, wn_i, err_o
  );

  modport slave (
    input  valid_i, sop_i, data_in_r, data_in_i,
    output ready_o, data_out_r, data_out_i, shift_en, sel,
           valid_o, sop_o, wn_r, wn_i, err_o
  );
endinterface

// File: rtl/sdf_twiddle_rom.sv
// Registered twiddle source: W = exp(-j*pi*n/DEPTH), zero when en is low.
module sdf_twiddle_rom
  import fft_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TW    = 8,
  localparam int unsigned LD   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [LD-1:0] n,
  output logic [TW-1:0] wn_r,
  output logic [TW-1:0] wn_i
);

  localparam int unsigned SHIFT = $clog2(N_MAX / 2) - LD;
  localparam logic [QTAB_LEN*QTAB_W-1:0] QTAB =
    (TW == 10) ? QTAB_TW10 : (TW == 8) ? QTAB_TW8 : gen_qtab(q_one(TW));

  logic [9:0]    addr;
  logic [9:0]    re_idx;
  logic [9:0]    im_idx;
  logic          re_neg;
  logic [TW-1:0] re_mag;
  logic [TW-1:0] im_mag;
  logic [TW-1:0] wn_r_d, wn_r_q;
  logic [TW-1:0] wn_i_d, wn_i_q;

  // Full half-circle folded onto the quarter table: cos mirrors about N_MAX/4,
  // and -sin is -cos of the distance from N_MAX/4.
  always_comb begin
    addr   = 10'(n) << SHIFT;
    re_neg = addr > 10'(QUARTER);
    re_idx = re_neg ? (10'(N_MAX / 2) - addr) : addr;
    im_idx = (addr >= 10'(QUARTER)) ? (addr - 10'(QUARTER)) : (10'(QUARTER) - addr);
    re_mag = QTAB[re_idx*QTAB_W +: TW];
    im_mag = QTAB[im_idx*QTAB_W +: TW];
    wn_r_d = '0;
    wn_i_d = '0;
    if (en) begin
      wn_r_d = re_neg ? -re_mag : re_mag;
      wn_i_d = -im_mag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wn_r_q <= '0;
      wn_i_q <= '0;
    end else begin
      wn_r_q <= wn_r_d;
      wn_i_q <= wn_i_d;
    end
  end

  assign wn_r = wn_r_q;
  assign wn_i = wn_i_q;

endmodule

// File: rtl/sdf_stage_ctrl.sv
// Control for one radix-2 SDF FFT stage of half-length DEPTH: frame alignment,
// stalls, back-to-back frames and autonomous drain of the pending h outputs.
module sdf_stage_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 8,
  parameter int unsigned TW    = 8
) (
  input  logic            clk,
  input  logic            rst,
  sdf_stage_ctrl_if.slave bus
);

  localparam int unsigned LD = $clog2(DEPTH);
  localparam int unsigned CW = LD + 1;
  localparam logic [CW-1:0] LAST_FILL  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] FIRST_BFLY = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_BFLY  = CW'(2 * DEPTH - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hpend_q, hpend_d;
  logic [DW-1:0] dr_q, dr_d;
  logic [DW-1:0] di_q, di_d;
  logic          shift_q, shift_d;
  logic          sel_q, sel_d;
  logic          valid_q, valid_d;
  logic          sop_q, sop_d;
  logic          err_q, err_d;
  logic          ready_q, ready_d;
  logic          tw_en;
  logic [LD-1:0] tw_n;
  logic          sop_in;

  assign sop_in = bus.valid_i & bus.sop_i;

  // FILL with cnt==0 is the single decision cycle after a frame's last sample:
  // a sop continues back-to-back, anything else commits to DRAIN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hpend_d = hpend_q;
    dr_d    = dr_q;
    di_d    = di_q;
    shift_d = 1'b0;
    sel_d   = 1'b0;
    valid_d = 1'b0;
    sop_d   = 1'b0;
    err_d   = 1'b0;
    tw_en   = 1'b0;
    tw_n    = '0;

    case (state_q)
      ST_IDLE: begin
        if (sop_in) begin
          dr_d    = bus.data_in_r;
          di_d    = bus.data_in_i;
          shift_d = 1'b1;
          cnt_d   = CW'(1);
          state_d = ST_FILL;
        end else if (bus.valid_i) begin
          err_d = 1'b1;
        end
      end

      ST_FILL, ST_BFLY: begin
        if (sop_in && cnt_q != '0) begin
          dr_d    = bus.data_in_r;
          di_d    = bus.data_in_i;
          shift_d = 1'b1;
          cnt_d   = CW'(1);
          hpend_d = 1'b0;
          err_d   = 1'b1;
          state_d = ST_FILL;
        end else if (state_q == ST_FILL && cnt_q == '0 && !sop_in) begin
          shift_d = 1'b1;
          valid_d = 1'b1;
          tw_en   = 1'b1;
          err_d   = bus.valid_i;
          cnt_d   = CW'(1);
          state_d = ST_DRAIN;
        end else if (bus.valid_i) begin
          dr_d    = bus.data_in_r;
          di_d    = bus.data_in_i;
          shift_d = 1'b1;
          cnt_d   = cnt_q + CW'(1);
          if (state_q == ST_FILL) begin
            valid_d = hpend_q;
            tw_en   = hpend_q;
            tw_n    = cnt_q[LD-1:0];
            if (cnt_q == LAST_FILL) begin
              hpend_d = 1'b0;
              state_d = ST_BFLY;
            end
          end else begin
            sel_d   = 1'b1;
            valid_d = 1'b1;
            sop_d   = (cnt_q == FIRST_BFLY);
            if (cnt_q == LAST_BFLY) begin
              hpend_d = 1'b1;
              cnt_d   = '0;
              state_d = ST_FILL;
            end
          end
        end
      end

      ST_DRAIN: begin
        shift_d = 1'b1;
        valid_d = 1'b1;
        tw_en   = 1'b1;
        tw_n    = cnt_q[LD-1:0];
        err_d   = bus.valid_i;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_FILL) begin
          hpend_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d != ST_DRAIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hpend_q <= 1'b0;
      dr_q    <= '0;
      di_q    <= '0;
      shift_q <= 1'b0;
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hpend_q <= hpend_d;
      dr_q    <= dr_d;
      di_q    <= di_d;
      shift_q <= shift_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  sdf_twiddle_rom #(
    .DEPTH(DEPTH),
    .TW   (TW)
  ) u_twiddle (
    .clk (clk),
    .rst (rst),
    .en  (tw_en),
    .n   (tw_n),
    .wn_r(bus.wn_r),
    .wn_i(bus.wn_i)
  );

  assign bus.ready_o    = ready_q;
  assign bus.data_out_r = dr_q;
  assign bus.data_out_i = di_q;
  assign bus.shift_en   = shift_q;
  assign bus.sel        = sel_q;
  assign bus.valid_o    = valid_q;
  assign bus.sop_o      = sop_q;
  assign bus.err_o      = err_q;

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Directed bench for sdf_stage_ctrl (DEPTH=16, TW=8) with a per-cycle scoreboard.
module tb_sdf_stage_ctrl;

  localparam int DEPTH = 16;
  localparam real PI   = 3.141592653589793;

  typedef struct packed {
    logic       ready;
    logic [7:0] dr;
    logic [7:0] di;
    logic       shift;
    logic       sel;
    logic       valid;
    logic       sop;
    logic [7:0] wr;
    logic [7:0] wi;
    logic       err;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sdf_stage_ctrl_if #(.DW(8), .TW(8)) bus ();

  sdf_stage_ctrl #(.DEPTH(DEPTH), .DW(8), .TW(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   vrun   = 0;
  int   vrun_max = 0;
  int   err_cnt = 0;
  out_t sb[$];

  // reference state
  int         m_k;
  bit         m_inframe;
  bit         m_pend;
  bit         m_owed;
  int         m_dn;
  logic [7:0] m_dr;
  logic [7:0] m_di;

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  function automatic logic [7:0] tw_re(input int n);
    return 8'(rnd(64.0 * $cos(PI * n / DEPTH)));
  endfunction

  function automatic logic [7:0] tw_im(input int n);
    return 8'(rnd(-64.0 * $sin(PI * n / DEPTH)));
  endfunction

  function automatic out_t observe();
    out_t o;
    o.ready = bus.ready_o;
    o.dr    = bus.data_out_r;
    o.di    = bus.data_out_i;
    o.shift = bus.shift_en;
    o.sel   = bus.sel;
    o.valid = bus.valid_o;
    o.sop   = bus.sop_o;
    o.wr    = bus.wn_r;
    o.wi    = bus.wn_i;
    o.err   = bus.err_o;
    return o;
  endfunction

  task automatic model_reset();
    m_k = 0; m_inframe = 0; m_pend = 0; m_owed = 0; m_dn = -1;
    m_dr = '0; m_di = '0;
  endtask

  task automatic model(input logic v, input logic s, input logic [7:0] r,
                       input logic [7:0] i, output out_t e);
    int h;
    h = -1;
    e = '0;
    if (m_dn >= 0) begin
      h = m_dn;
      e.err = v;
      m_dn++;
      if (m_dn == DEPTH) begin m_dn = -1; m_owed = 0; end
    end else if (m_pend) begin
      m_pend = 0;
      h = 0;
      if (v && s) begin
        m_dr = r; m_di = i; e.shift = 1;
        m_inframe = 1; m_k = 1;
      end else begin
        e.err = v;
        m_dn = 1;
      end
    end else if (!m_inframe) begin
      if (v && s) begin
        m_dr = r; m_di = i; e.shift = 1;
        m_inframe = 1; m_k = 1;
      end else if (v) begin
        e.err = 1;
      end
    end else if (v && s) begin
      m_dr = r; m_di = i; e.shift = 1;
      m_k = 1; m_owed = 0; e.err = 1;
    end else if (v) begin
      m_dr = r; m_di = i; e.shift = 1;
      if (m_k < DEPTH) begin
        if (m_owed) h = m_k;
        if (m_k == DEPTH - 1) m_owed = 0;
      end else begin
        e.sel = 1; e.valid = 1; e.sop = (m_k == DEPTH);
      end
      m_k++;
      if (m_k == 2 * DEPTH) begin m_inframe = 0; m_pend = 1; m_owed = 1; end
    end
    if (h >= 0) begin
      e.shift = 1; e.valid = 1; e.wr = tw_re(h); e.wi = tw_im(h);
    end
    e.dr = m_dr;
    e.di = m_di;
    e.ready = (m_dn < 0);
  endtask

  task automatic step(input string tag, input logic v, input logic s);
    out_t e;
    out_t o;
    logic [7:0] r;
    logic [7:0] i;
    r = 8'($urandom);
    i = 8'($urandom);
    @(negedge clk);
    bus.valid_i = v; bus.sop_i = s; bus.data_in_r = r; bus.data_in_i = i;
    model(v, s, r, i, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = observe();
    e = sb.pop_front();
    cyc++;
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, o, e);
    end
    if (o.err) err_cnt++;
    if (o.valid) begin
      vrun++;
      if (vrun > vrun_max) vrun_max = vrun;
    end else begin
      vrun = 0;
    end
  endtask

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic idle(input string tag, input int n);
    for (int c = 0; c < n; c++) step(tag, 1'b0, 1'b0);
  endtask

  task automatic feed(input string tag, input int nsamp, input int stall_period);
    int sent;
    int c;
    sent = 0;
    c = 0;
    while (sent < nsamp) begin
      c++;
      if (stall_period != 0 && (c % stall_period) == 0) begin
        step(tag, 1'b0, 1'b0);
      end else begin
        step(tag, 1'b1, sent == 0);
        sent++;
      end
    end
  endtask

  initial begin
    out_t rst_exp;
    out_t o;
    rst_exp = '0;
    rst_exp.ready = 1'b1;
    bus.valid_i = 1'b0; bus.sop_i = 1'b0; bus.data_in_r = '0; bus.data_in_i = '0;
    model_reset();

    #12;
    o = observe();
    n_chk++;
    assert (o === rst_exp) else begin
      n_fail++;
      $error("FAIL reset got=%h exp=%h", o, rst_exp);
    end
    @(negedge clk) rst = 1'b0;

    idle("pre", 2);
    vrun_max = 0;
    feed("single", 32, 0);
    idle("single_drain", 20);
    check("single_vrun", vrun_max, 32);

    vrun_max = 0;
    feed("b2b_f1", 32, 0);
    feed("b2b_f2", 32, 0);
    idle("b2b_drain", 20);
    check("b2b_vrun", vrun_max, 64);

    feed("stall", 32, 3);
    idle("stall_drain", 20);

    err_cnt = 0;
    feed("resync_bfly_a", 26, 0);
    feed("resync_bfly_b", 32, 0);
    idle("resync_bfly_drain", 20);
    check("resync_bfly_err", err_cnt, 1);

    err_cnt = 0;
    feed("resync_fill_a", 32, 0);
    feed("resync_fill_b", 5, 0);
    feed("resync_fill_c", 32, 0);
    idle("resync_fill_drain", 20);
    check("resync_fill_err", err_cnt, 1);

    err_cnt = 0;
    vrun_max = 0;
    step("err_idle", 1'b1, 1'b0);
    idle("err_gap", 2);
    feed("err_frame", 32, 0);
    step("err_drain0", 1'b0, 1'b0);
    step("err_drain_v", 1'b1, 1'b0);
    step("err_drain_v", 1'b1, 1'b0);
    step("err_late_sop", 1'b1, 1'b1);
    idle("err_drain", 20);
    check("err_count", err_cnt, 4);
    check("err_drain_len", vrun_max, 32);

    feed("rst_mid", 20, 0);
    @(negedge clk);
    rst = 1'b1;
    bus.valid_i = 1'b0; bus.sop_i = 1'b0;
    #1;
    o = observe();
    n_chk++;
    assert (o === rst_exp) else begin
      n_fail++;
      $error("FAIL rst_mid got=%h exp=%h", o, rst_exp);
    end
    model_reset();
    sb.delete();
    vrun = 0;
    @(negedge clk) rst = 1'b0;
    idle("post_rst", 3);
    vrun_max = 0;
    feed("post_rst_frame", 32, 0);
    idle("post_rst_drain", 20);
    check("post_rst_vrun", vrun_max, 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
